// File: rtl/arith_pipe_unit.sv
// arith_pipe_unit: handshaked WIDTH-bit add/sub/ADC/SBB unit with registered flags; shift-add MUL when ARITH_MUL_EN is defined
module arith_pipe_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n,
  output logic             busy
);
  localparam int MSB = WIDTH - 1;
  logic             r_cf;
  logic             w_idle, w_accept, w_load;
  logic             w_arith, w_cin, w_c, w_v, w_lc, w_lv;
  logic [WIDTH-1:0] w_addend, w_res, w_lres;
  logic [WIDTH:0]   w_sum;
  assign in_ready = !rst && w_idle && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  always_comb begin
    w_arith  = opcode inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    w_addend = (opcode == 4'h4 || opcode == 4'h8) ? b :
               (opcode == 4'h5) ? WIDTH'(1) :
               (opcode == 4'h7) ? ~WIDTH'(1) : ~b;
    w_cin    = opcode[3] ? r_cf : opcode[1];
    w_sum    = {1'b0, a} + {1'b0, w_addend} + (WIDTH + 1)'(w_cin);
    w_res    = w_arith ? w_sum[MSB:0] : '0;
    w_c      = w_arith && w_sum[WIDTH];
    w_v      = w_arith && (a[MSB] == w_addend[MSB]) && (w_sum[MSB] != a[MSB]);
  end
`ifdef ARITH_MUL_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t             r_state, w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc, r_mcand, w_acc_nx;
  logic [WIDTH-1:0]   r_mplier;
  logic               w_mul_go, w_done;
  always_comb begin
    w_mul_go   = w_accept && opcode == 4'hA;
    w_done     = r_state == S_MUL && r_cnt == CW'(WIDTH - 1);
    w_acc_nx   = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_state_nx = w_mul_go ? S_MUL : w_done ? S_IDLE : r_state;
    w_idle     = r_state == S_IDLE;
    w_load     = (w_accept && !w_mul_go) || w_done;
    w_lres     = w_done ? w_acc_nx[MSB:0] : w_res;
    w_lc       = w_done ? |w_acc_nx[2*WIDTH-1:WIDTH] : w_c;
    w_lv       = w_done ? |w_acc_nx[2*WIDTH-1:WIDTH] : w_v;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_mul_go) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, a};
        r_mplier <= b;
      end else if (r_state == S_MUL) begin
        r_cnt    <= w_done ? '0 : r_cnt + CW'(1);
        r_acc    <= w_acc_nx;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
    end
  end
  assign busy = r_state == S_MUL;
`else
  always_comb begin
    w_idle = 1'b1;
    w_load = w_accept;
    w_lres = w_res;
    w_lc   = w_c;
    w_lv   = w_v;
  end
  assign busy = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      c         <= 1'b0;
      v         <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
      r_cf      <= 1'b0;
    end else begin
      out_valid <= w_load || (out_valid && !out_ready);
      if (w_load) begin
        result <= w_lres;
        c      <= w_lc;
        v      <= w_lv;
        z      <= w_lres == '0;
        n      <= w_lres[MSB];
        r_cf   <= w_lc;
      end
    end
  end
endmodule

// File: tb/tb_arith_pipe_unit.sv
// tb_arith_pipe_unit: table-driven and hand-sequenced checks of arith_pipe_unit at WIDTH=4
module tb_arith_pipe_unit;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] opcode = '0, a = '0, b = '0;
  logic       in_ready, out_valid, c, v, z, n, busy;
  logic [3:0] result;
  int         tests = 0, failed = 0;
  typedef struct {
    logic [3:0] op, x, y, res;
    logic       ec, ev, ez, en;
  } vec_t;
  vec_t tv[15];
  arith_pipe_unit #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .c(c), .v(v), .z(z), .n(n), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [8:0] o();
    return {out_valid, result, c, v, z, n};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
    opcode = op;
    a = x;
    b = y;
    in_valid = 1'b1;
    #1;
    chk("send_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  initial begin
    tv[0]  = '{4'h4, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[1]  = '{4'h6, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[2]  = '{4'h6, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[3]  = '{4'h4, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[4]  = '{4'h8, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{4'h9, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[6]  = '{4'h5, 4'h7, 4'h0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[7]  = '{4'h7, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[8]  = '{4'h7, 4'h8, 4'h0, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{4'h8, 4'h7, 4'h0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[10] = '{4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[11] = '{4'h4, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0};
    tv[12] = '{4'h9, 4'h5, 4'h3, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[13] = '{4'h0, 4'h9, 4'h9, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[14] = '{4'h8, 4'hF, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    chk("reset_state", {in_ready, busy, o()}, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", in_ready, 1);
    for (int i = 0; i <= 15; i++) begin
      if (i > 0)
        chk($sformatf("vec%0d", i - 1), o(),
            {1'b1, tv[i-1].res, tv[i-1].ec, tv[i-1].ev, tv[i-1].ez, tv[i-1].en});
      if (i < 15) begin
        opcode = tv[i].op;
        a = tv[i].x;
        b = tv[i].y;
        in_valid = 1'b1;
        #1;
        chk($sformatf("vec%0d_ready", i), in_ready, 1);
      end else in_valid = 1'b0;
      @(negedge clk);
    end
    opcode = 4'h4; a = 4'h2; b = 4'h3; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    a = 4'h1; b = 4'h1;
    #1;
    chk("bp_result", o(), {1'b1, 4'h5, 4'h0});
    chk("bp_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    chk("bp_hold", o(), {1'b1, 4'h5, 4'h0});
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_reload", o(), {1'b1, 4'h2, 4'h0});
    @(negedge clk);
    chk("drain_retain", o(), {1'b0, 4'h2, 4'h0});
`ifdef ARITH_MUL_EN
    send(4'hA, 4'h5, 4'h3);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("mul1_wait%0d", k), {busy, in_ready, out_valid}, 3'b100);
      @(negedge clk);
    end
    chk("mul1_result", o(), {1'b1, 4'hF, 4'b0001});
    chk("mul1_busy_done", busy, 0);
    send(4'hA, 4'h6, 4'h5);
    repeat (4) @(negedge clk);
    chk("mul2_result", o(), {1'b1, 4'hE, 4'b1101});
`else
    send(4'hA, 4'h6, 4'h5);
    chk("op1010_unsupported", {busy, o()}, {1'b0, 1'b1, 4'h0, 4'b0010});
`endif
    send(4'h4, 4'hF, 4'h3);
    chk("pre_reset_add", o(), {1'b1, 4'h2, 4'b1000});
`ifdef ARITH_MUL_EN
    opcode = 4'hA; a = 4'h7; b = 4'h7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_reset_clear", {busy, o()}, 0);
    @(negedge clk);
    chk("mid_reset_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("no_valid%0d", k), {busy, out_valid}, 0);
      @(negedge clk);
    end
    send(4'h8, 4'h0, 4'h0);
    chk("cf_cleared_adc", o(), {1'b1, 4'h0, 4'b0010});
    send(4'h4, 4'h1, 4'h1);
    send(4'hF, 4'h5, 4'h5);
    chk("op1111_unsupported", o(), {1'b1, 4'h0, 4'b0010});
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
